shift_add_multiplier: RTL and testbench

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/shift_add_multiplier.sv | 64 ++++++
 tb/tb_shift_add_multiplier.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential shift-and-add multiplier, one partial product per cycle plus a sign-fixup cycle
module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] dataOut
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;
    state_t state;
    logic [2*WIDTH-1:0] mcand, acc;
    logic [WIDTH-1:0] mplier, mag_a, mag_b;
    logic [CW-1:0] count;
    logic neg;
    // Magnitudes are taken as unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1) without overflow
    always_comb begin
        mag_a = (is_signed && dataA[WIDTH-1]) ? -dataA : dataA;
        mag_b = (is_signed && dataB[WIDTH-1]) ? -dataB : dataB;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            dataOut <= '0;
            acc     <= '0;
            count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state  <= RUN;
                    busy   <= 1'b1;
                    acc    <= '0;
                    count  <= '0;
                    mcand  <= {{WIDTH{1'b0}}, mag_a};
                    mplier <= mag_b;
                    neg    <= is_signed & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
                end
                RUN: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) state <= SIGN;
                end
                SIGN: begin
                    dataOut <= neg ? -acc : acc;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed checks of a 32-bit and an 8-bit multiplier instance
module tb_shift_add_multiplier;
    logic        clk = 1'b0;
    logic        reset;
    logic        start, is_signed, busy, done;
    logic [31:0] dataA, dataB;
    logic [63:0] dataOut;
    logic        start8, s8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] out8;
    int checks = 0;
    int errors = 0;
    int nd, lat;

    shift_add_multiplier #(.WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .dataA(dataA), .dataB(dataB), .busy(busy), .done(done), .dataOut(dataOut)
    );
    shift_add_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .is_signed(s8),
        .dataA(a8), .dataB(b8), .busy(busy8), .done(done8), .dataOut(out8)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are scrambled right after acceptance so any late sampling corrupts the product
    task automatic run_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp, input string tag);
        int n;
        if (sel) begin
            a8 = a[7:0]; b8 = b[7:0]; s8 = s; start8 = 1'b1;
        end else begin
            dataA = a; dataB = b; is_signed = s; start = 1'b1;
        end
        tick;
        start = 1'b0; start8 = 1'b0;
        dataA = ~dataA; dataB = ~dataB; is_signed = ~is_signed;
        a8 = ~a8; b8 = ~b8; s8 = ~s8;
        check({tag, "_busy"}, sel ? busy8 : busy, 1'b1);
        n = 0;
        while (!(sel ? done8 : done) && n < 100) begin
            tick;
            n++;
        end
        check({tag, "_lat"}, n, sel ? 9 : 33);
        check({tag, "_val"}, sel ? {48'd0, out8} : dataOut, exp);
        tick;
        check({tag, "_done_fall"}, sel ? done8 : done, 1'b0);
        check({tag, "_idle"}, sel ? busy8 : busy, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; dataA = '0; dataB = '0;
        start8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0;
        tick; tick;
        reset = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out", dataOut, 64'd0);

        run_op(0, 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, "u3x5");
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "umax");
        run_op(0, 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "sm3x5");
        run_op(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "smin2");
        run_op(0, 32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, "sminx1");
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1, "sm1m1");
        run_op(0, 32'hFFFF_FFFF, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFE, "uffx2");
        run_op(0, 32'hFFFF_FFFF, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, "sm1x2");
        run_op(0, 32'd0, 32'h1234_5678, 1'b1, 64'd0, "zero");

        // start held high throughout: second op picks up the dataA changed mid-run
        dataA = 32'd6; dataB = 32'd7; is_signed = 1'b0; start = 1'b1;
        tick;
        nd = 0;
        for (int t = 1; t <= 70; t++) begin
            tick;
            if (t == 5) dataA = 32'd100;
            if (done) begin
                if (nd == 0) begin
                    check("hold_t1", t, 33);
                    check("hold_v1", dataOut, 64'd42);
                end else begin
                    check("hold_t2", t, 67);
                    check("hold_v2", dataOut, 64'd700);
                    start = 1'b0;
                end
                nd++;
            end
        end
        start = 1'b0;
        check("hold_ndone", nd, 2);
        check("hold_idle", busy, 1'b0);

        // reset in the middle of RUN aborts with no done and clears dataOut
        dataA = 32'd7; dataB = 32'd9; is_signed = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (10) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_out", dataOut, 64'd0);
        nd = 0;
        repeat (40) begin
            tick;
            if (done) nd++;
        end
        check("abort_nodone", nd, 0);
        check("abort_out_hold", dataOut, 64'd0);
        run_op(0, 32'd2, 32'd2, 1'b0, 64'd4, "post2x2");

        // reset beats start, then start is taken on the first edge after reset drops
        reset = 1'b1; start = 1'b1; dataA = 32'd3; dataB = 32'd3; is_signed = 1'b0;
        tick;
        check("prio_busy", busy, 1'b0);
        reset = 1'b0;
        tick;
        start = 1'b0;
        check("prio_accept", busy, 1'b1);
        lat = 0;
        while (!done && lat < 100) begin
            tick;
            lat++;
        end
        check("prio_lat", lat, 33);
        check("prio_val", dataOut, 64'd9);

        run_op(1, 32'h80, 32'hFF, 1'b1, 64'h0080, "w8_signed");
        run_op(1, 32'h80, 32'hFF, 1'b0, 64'h7F80, "w8_unsigned");
        run_op(1, 32'hFF, 32'hFF, 1'b0, 64'hFE01, "w8_umax");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
